sram_4kx32: RTL and testbench
=============================

SRAM_4KX32 -- requirements
Module: sram_4kx32

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, number of 32-bit words.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, bus byte-address width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port mbus, memory_bus interface in slave modport, carrying the signals in REQ-008 to REQ-014.
REQ-008 SHALL take mbus.req, input, 1 bit, access request, valid for one cycle per access.
REQ-009 SHALL take mbus.we, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL take mbus.addr, input, ADDR_W bits, byte address.
REQ-011 SHALL take mbus.be, input, 4 bits, byte-lane enables for writes; be[i] selects bits [8i+7:8i].
REQ-012 SHALL take mbus.wdata, input, DATA_W bits, write data.
REQ-013 SHALL drive mbus.rdata, output, DATA_W bits, read data.
REQ-014 SHALL drive mbus.ack, output, 1 bit, one-cycle completion strobe.

Function
REQ-015 SHALL hold storage in an unpacked array named mem, DEPTH x DATA_W, indexed 0..DEPTH-1, so benches can load it by hierarchical $readmemh (inst.mem).
REQ-016 SHALL form the word index from addr[13:2]; addr[1:0] are ignored, so misaligned accesses go to the containing word.
REQ-017 SHALL treat addr[ADDR_W-1:14] != 0 as out of range: writes are dropped, reads return 0, and ack is still given.
REQ-018 SHALL sample req, we, addr, be and wdata on the rising clk edge.
REQ-019 SHALL raise ack for exactly one cycle, in the cycle after each sampled req (1-cycle latency), for both reads and writes.
REQ-020 SHALL write, on a write, only the byte lanes with be[i]=1 at the sampling edge; lanes with be[i]=0 keep their old value; be=0 writes nothing but still acks.
REQ-021 SHALL register mbus.rdata on a read at the sampling edge so it is valid in the ack cycle, and hold it until the next read completes.
REQ-022 SHALL keep mbus.rdata unchanged when a write completes.
REQ-023 SHALL accept back-to-back requests every cycle with no bubbles, giving one ack per req in order.
REQ-024 SHALL return the updated value when a read to address A is sampled the cycle after a write to A (write-then-read ordering).
REQ-025 SHALL NOT perform any bus-side ready/backpressure handshake; it is always ready.

Reset
REQ-026 SHALL clear ack to 0 and rdata to 0 immediately while rst=0, independent of clk.
REQ-027 SHALL ignore req while rst=0, with no memory writes.
REQ-028 SHALL NOT clear mem on reset, so preloaded contents survive reset.
REQ-029 SHALL discard a request sampled in the cycle reset asserts; after rst deasserts, the first ack comes only for a req sampled after deassertion.

Structure
REQ-030 SHALL take DATA_W, DEPTH, word-index width (12) and the byte-enable width (4) from a shared package, mem_pkg.
REQ-031 SHALL have memory_bus defined as a separate SystemVerilog interface with modports master (req, we, addr, be, wdata out; rdata, ack in) and slave.
REQ-032 SHALL have no sub-module; the byte-lane write merge is coded inline.

Verification
REQ-033 SHALL be tested with preload mem[0]=32'h00000013 via $readmemh, then a read at addr 0: ack one cycle later, rdata=32'h00000013.
REQ-034 SHALL be tested with write addr 0x10, wdata 32'hDEADBEEF, be=4'b1111, then write be=4'b0010, wdata 32'h0000AA00, then a read at 0x10: rdata=32'hDEADAAEF.
REQ-035 SHALL be tested with back-to-back reads at 0x0, 0x4, 0x8 in consecutive cycles: three consecutive ack pulses with matching data in order.
REQ-036 SHALL be tested with a write to addr 0x4000 (out of range) and a read at 0x4000: ack given, rdata=0, mem[0] unchanged.
REQ-037 SHALL be tested by asserting rst=0 mid-stream between clock edges: ack and rdata drop to 0 at once, mem contents are kept, and a read after release returns the preloaded value.

Source files
------------

// File: rtl/sram_4kx32_pkg.sv
// Shared sizing constants for the 4K x 32 single-port SRAM and its bus.
package mem_pkg;

    // Storage geometry
    localparam int MEM_DATA_W = 32;
    localparam int MEM_DEPTH  = 4096;
    localparam int MEM_IDX_W  = 12;
    localparam int MEM_BE_W   = 4;

    // Byte address bits below the word index (addr[1:0] select a byte)
    localparam int MEM_BYTE_OFS_W = 2;

    // Lowest address bit that must be zero for an in-range access
    localparam int MEM_OOR_LSB = MEM_IDX_W + MEM_BYTE_OFS_W;

    // Access kind as carried by the we bit
    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_kind_e;

endpackage

// File: rtl/sram_4kx32_if.sv
// Simple request/ack memory bus: one-cycle req strobe, one-cycle ack strobe.
interface memory_bus
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = MEM_DATA_W,
    parameter int BE_W   = MEM_BE_W
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req,
        output we,
        output addr,
        output be,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  be,
        input  wdata,
        output rdata,
        output ack
    );

endinterface

// File: rtl/sram_4kx32.sv
// 4K x 32 single-port SRAM with byte-lane writes and a fixed one-cycle
// request-to-ack latency. Always ready; out-of-range accesses are acked,
// writes dropped and reads return zero. Storage is not touched by reset.
module sram_4kx32
    import mem_pkg::*;
#(
    parameter int DEPTH  = MEM_DEPTH,
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    memory_bus.slave  mbus
);

    // Storage, kept as a plain unpacked array so it can be preloaded
    // hierarchically (inst.mem).
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [MEM_IDX_W-1:0] word_idx;
    logic                 in_range;
    logic                 wr_en;
    logic                 rd_en;
    logic [MEM_BE_W-1:0]  lane_we;

    logic                 ack_reg;
    logic [DATA_W-1:0]    rdata_reg;

    // Word index from addr[13:2]; byte offset bits are ignored so a
    // misaligned access lands on the containing word.
    assign word_idx = mbus.addr[MEM_OOR_LSB-1:MEM_BYTE_OFS_W];
    assign in_range = (mbus.addr[ADDR_W-1:MEM_OOR_LSB] == '0);

    // Requests seen while reset is held are ignored entirely.
    assign wr_en = rst && mbus.req && (acc_kind_e'(mbus.we) == ACC_WRITE) && in_range;
    assign rd_en = rst && mbus.req && (acc_kind_e'(mbus.we) == ACC_READ);

    // Per-lane write strobes
    generate
        for (genvar gi = 0; gi < MEM_BE_W; gi++) begin : g_lane_we
            assign lane_we[gi] = wr_en && mbus.be[gi];
        end
    endgenerate

    // Byte-lane write merge: only enabled lanes are updated, others keep
    // their previous contents. No reset so preloaded data survives.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MEM_BE_W; i++) begin
            if (lane_we[i]) begin
                mem[word_idx][8*i +: 8] <= mbus.wdata[8*i +: 8];
            end
        end
    end

    // Ack strobe and registered read data; rdata holds across write acks
    // and idle cycles until the next read completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ack_reg <= mbus.req;
            if (rd_en) begin
                rdata_reg <= in_range ? mem[word_idx] : '0;
            end
        end
    end

    assign mbus.ack   = ack_reg;
    assign mbus.rdata = rdata_reg;

endmodule

// File: tb/tb_sram_4kx32.sv
// Scoreboard bench for sram_4kx32: the driver pushes the expected response
// for each request, a monitor on the falling edge pops and compares on ack.
module tb_sram_4kx32;

    logic clk;
    logic rst;

    memory_bus #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) bus ();

    sram_4kx32 #(.DEPTH(4096), .DATA_W(32), .ADDR_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .mbus (bus)
    );

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_vec   = 0;
    int          n_bad   = 0;
    int          neg_cnt = 0;
    logic [31:0] last_rd = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Issue one request in the next cycle; for reads exp is the data due
    // on the ack, for writes it is ignored (rdata must hold the last read).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        #1;
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.be    = be;
        bus.wdata = wd;
        e.rd   = !we;
        e.data = exp;
        e.due  = neg_cnt + 1;
        sb.push_back(e);
        $display("req %s addr=%h be=%b wdata=%h exp=%h", we ? "WR" : "RD", addr, be, wd, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            bus.req = 1'b0;
        end
    endtask

    // Monitor: checks every falling edge, pops on expected acks.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (!rst) begin
                chk("rst_ack", {31'b0, bus.ack}, 32'h0);
                chk("rst_rdata", bus.rdata, 32'h0);
            end else if (sb.size() > 0 && sb[0].due == neg_cnt) begin
                e = sb.pop_front();
                chk("ack", {31'b0, bus.ack}, 32'h1);
                if (e.rd) begin
                    chk("rd_data", bus.rdata, e.data);
                    last_rd = e.data;
                end else begin
                    chk("wr_rdata_hold", bus.rdata, last_rd);
                end
                $display("ack %s rdata=%h", e.rd ? "RD" : "WR", bus.rdata);
            end else begin
                chk("idle_ack", {31'b0, bus.ack}, 32'h0);
            end
        end
    end

    // Stimulus
    initial begin
        rst       = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.be    = '0;
        bus.wdata = '0;
        dut.mem[0] = 32'h00000013;
        dut.mem[1] = 32'h11111111;
        dut.mem[2] = 32'h22222222;

        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        // Preloaded word, 1-cycle latency
        issue(1'b0, 32'h0, 4'h0, 32'h0, 32'h00000013);
        idle(1);

        // Full write, partial lane write, then immediate read-back
        issue(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0);
        issue(1'b1, 32'h10, 4'b0010, 32'h0000AA00, 32'h0);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF);
        idle(1);

        // Back-to-back reads
        issue(1'b0, 32'h0, 4'h0, 32'h0, 32'h00000013);
        issue(1'b0, 32'h4, 4'h0, 32'h0, 32'h11111111);
        issue(1'b0, 32'h8, 4'h0, 32'h0, 32'h22222222);
        idle(1);

        // Misaligned write/read hit the containing word
        issue(1'b1, 32'h13, 4'b0001, 32'h00000055, 32'h0);
        issue(1'b0, 32'h12, 4'h0, 32'h0, 32'hDEADAA55);
        // be=0 writes nothing
        issue(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADAA55);
        idle(1);

        // Out of range: write dropped, read zero, mem[0] untouched
        issue(1'b1, 32'h4000, 4'b1111, 32'hCAFEF00D, 32'h0);
        issue(1'b0, 32'h4000, 4'h0, 32'h0, 32'h0);
        issue(1'b0, 32'h0, 4'h0, 32'h0, 32'h00000013);
        issue(1'b0, 32'h80000010, 4'h0, 32'h0, 32'h0);
        issue(1'b1, 32'h20, 4'b1111, 32'hAAAAAAAA, 32'h0);
        issue(1'b1, 32'h20, 4'b1100, 32'h12345678, 32'h0);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h1234AAAA);
        idle(2);

        // Reset mid-stream between edges
        @(negedge clk);
        #1;
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'h8;
        @(posedge clk);
        #2;
        chk("pre_rst_ack", {31'b0, bus.ack}, 32'h1);
        chk("pre_rst_rdata", bus.rdata, 32'h22222222);
        rst = 1'b0;
        last_rd = 32'h0;
        #1;
        chk("async_rst_ack", {31'b0, bus.ack}, 32'h0);
        chk("async_rst_rdata", bus.rdata, 32'h0);
        // Write attempt while in reset must be ignored
        @(negedge clk);
        #1;
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h0;
        bus.be    = 4'b1111;
        bus.wdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        #1;
        bus.req = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        idle(1);

        issue(1'b0, 32'h0, 4'h0, 32'h0, 32'h00000013);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h1234AAAA);
        idle(3);

        chk("sb_drained", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
